// File: rtl/exc_pkg.sv
// Shared types and cause codes for the exception/interrupt controller.
// Cause codes are 4 bits wide; IRQ causes carry the channel in the low bits.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    HANDLER
  } exc_state_e;

  localparam logic [3:0] ESTATUS_NONE     = 4'b0000;
  localparam logic [3:0] ESTATUS_INVOP    = 4'b0010;
  localparam logic [3:0] ESTATUS_IRQ_BASE = 4'b1000;

  function automatic logic [3:0] irq_code(input logic [2:0] k);
    return ESTATUS_IRQ_BASE | {1'b0, k};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of req wins.
// valid is low and idx is zero when no request bit is set.
module irq_prio_enc #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  assign valid = |req;

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: pending IRQ latches, fixed-priority
// cause select, Exc/ExcAck/ERet handshake, ELR and EStatus registers.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int N_IRQ     = 4,
  parameter int ESTATUS_W = 4,
  parameter int PC_W      = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     ExtIRQ,
  input  logic [N_IRQ-1:0]     IrqMask,
  input  logic                 NotAnInstr,
  input  logic                 ERet,
  input  logic                 ExcAck,
  input  logic [PC_W-1:0]      PC,
  output logic                 Exc,
  output logic [N_IRQ-1:0]     ExtIAck,
  output logic [ESTATUS_W-1:0] EStatus,
  output logic [PC_W-1:0]      ELR,
  output logic                 DoubleFault
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  exc_state_e       state_q, state_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             irq_cause_q, irq_cause_d;
  logic [3:0]       est_q, est_d;
  logic [PC_W-1:0]  elr_q, elr_d;
  logic             dfault_q, dfault_d;

  logic [N_IRQ-1:0] irq_req;
  logic [N_IRQ-1:0] ack;
  logic             enc_valid;
  logic [IDX_W-1:0] enc_idx;
  logic             req_any;
  logic [3:0]       req_code;
  logic             exc;

  assign irq_req = (pend_q | ExtIRQ) & IrqMask;

  irq_prio_enc #(
    .N (N_IRQ)
  ) u_enc (
    .req   (irq_req),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign req_any = NotAnInstr | enc_valid;

  // Cause code of the current winner; invalid opcode beats every IRQ.
  always_comb begin
    req_code = ESTATUS_NONE;
    if (NotAnInstr)     req_code = ESTATUS_INVOP;
    else if (enc_valid) req_code = irq_code(3'(enc_idx));
  end

  // Handshake next-state, register updates and acknowledge pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    irq_cause_d = irq_cause_q;
    est_d       = est_q;
    elr_d       = elr_q;
    dfault_d    = dfault_q;
    exc         = 1'b0;
    ack         = '0;
    unique case (state_q)
      IDLE: begin
        exc = req_any;
        if (req_any) begin
          elr_d       = PC;
          est_d       = req_code;
          irq_cause_d = ~NotAnInstr;
          idx_d       = enc_idx;
          if (ExcAck) begin
            state_d = HANDLER;
            if (!NotAnInstr) ack = N_IRQ'(1) << enc_idx;
          end else begin
            state_d = TAKE;
          end
        end
      end
      TAKE: begin
        exc = 1'b1;
        if (ExcAck) begin
          state_d = HANDLER;
          if (irq_cause_q) ack = N_IRQ'(1) << idx_q;
        end
      end
      HANDLER: begin
        if (NotAnInstr) dfault_d = 1'b1;
        if (ERet) begin
          state_d = IDLE;
          est_d   = ESTATUS_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) ack = '0;
    pend_d = (pend_q | ExtIRQ) & ~ack;
  end

  // State and architectural registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      idx_q       <= '0;
      irq_cause_q <= 1'b0;
      est_q       <= ESTATUS_NONE;
      elr_q       <= '0;
      dfault_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      irq_cause_q <= irq_cause_d;
      est_q       <= est_d;
      elr_q       <= elr_d;
      dfault_q    <= dfault_d;
    end
  end

  assign Exc         = exc & ~reset;
  assign ExtIAck     = ack;
  assign EStatus     = reset ? '0 :
                       ESTATUS_W'((state_q == IDLE) ? req_code : est_q);
  assign ELR         = elr_q;
  assign DoubleFault = dfault_q;

endmodule
